// File: rtl/counter_pkg.sv
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared definitions for the counter family: direction and
//             boundary-mode encodings plus the terminal-value (MAX) helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    // Encodings of the 'up' and 'sat' control inputs.
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // The helper works on a fixed 64-bit datapath. Callers zero-extend
    // their modulus into it and truncate the result back to their own
    // width, so any counter up to 64 bits can share it.
    localparam int CNT_MAX_W = 64;

    // MAX = mod_val - 1, or all ones when mod_val is 0 (full range).
    // After truncation to the caller's width, all ones is 2^WIDTH - 1.
    function automatic logic [CNT_MAX_W-1:0] cnt_max(input logic [CNT_MAX_W-1:0] mod_val);
        if (mod_val == '0) begin
            return '1;
        end
        return mod_val - {{(CNT_MAX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_updown_counter_cnt_next_logic.sv
// ============================================================================
//  Module   : cnt_next_logic
//  Purpose  : Combinational next-count and boundary-event decode for the
//             up/down counter.
//  Ports    : cnt      - current count
//             max_val  - terminal value for this cycle
//             clr, load, load_val, en, up, sat - control inputs
//             nxt_cnt  - count to be registered at the next edge
//             evt_tc   - a boundary event happens at the next edge
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_next_logic
    import counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] nxt_cnt,
    output logic             evt_tc
);

    always_comb begin
        nxt_cnt = cnt;
        evt_tc  = 1'b0;
        if (clr) begin
            nxt_cnt = '0;
        end else if (load) begin
            // Loaded values are clamped into the current range.
            nxt_cnt = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (cnt > max_val) begin
                // Modulus shrank under a running count: re-enter the range
                // at the end the direction is heading away from. This is a
                // recovery, not a boundary event.
                nxt_cnt = (up == DIR_UP) ? '0 : max_val;
            end else if (up == DIR_UP) begin
                if (cnt == max_val) begin
                    evt_tc  = 1'b1;
                    nxt_cnt = (sat == MODE_WRAP) ? '0 : max_val;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end else if (up == DIR_DN) begin
                if (cnt == '0) begin
                    evt_tc  = 1'b1;
                    nxt_cnt = (sat == MODE_SAT) ? '0 : max_val;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mod_updown_counter.sv
// ============================================================================
//  Module   : mod_updown_counter
//  Purpose  : Up/down counter with runtime modulus, synchronous clear/load,
//             wrap or saturate at the boundaries, a one-cycle terminal-count
//             pulse and a sticky boundary flag. WIDTH must be 2..64.
//  Ports    : clk, rst_n (async active-low), clr, load, load_val, en, up,
//             sat, mod_val (0 = full range) ; outputs cnt, tc, ovf
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] nxt_cnt;
    logic             evt_tc;

    // Widen into the helper's datapath, truncate back to WIDTH bits.
    assign max_val = WIDTH'(cnt_max(CNT_MAX_W'(mod_val)));

    cnt_next_logic #(
        .WIDTH (WIDTH)
    ) u_next (
        .cnt      (cnt),
        .max_val  (max_val),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .sat      (sat),
        .nxt_cnt  (nxt_cnt),
        .evt_tc   (evt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RESET_VAL;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            cnt <= nxt_cnt;
            tc  <= evt_tc;
            if (clr) begin
                ovf <= 1'b0;
            end else if (evt_tc) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`timescale 1ns/1ps
`default_nettype none

module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, load, en, up, sat;
    logic [3:0] load_val, mod_val;
    logic [3:0] cnt;
    logic       tc, ovf;

    typedef struct {
        string      name;
        logic [3:0] cnt;
        logic       tc;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(
        .WIDTH     (4),
        .RESET_VAL (4'd3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .sat      (sat),
        .mod_val  (mod_val),
        .cnt      (cnt),
        .tc       (tc),
        .ovf      (ovf)
    );

    task automatic compare(input string name, input logic [3:0] ec,
                           input logic et, input logic eo);
        n_checks++;
        if (cnt !== ec || tc !== et || ovf !== eo) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d tc=%b ovf=%b, expected cnt=%0d tc=%b ovf=%b",
                     name, cnt, tc, ovf, ec, et, eo);
        end
    endtask

    // Monitor: outputs are valid every cycle; check half a cycle after
    // each rising edge whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare(e.name, e.cnt, e.tc, e.ovf);
            end
        end
    end

    // Inputs are already set; queue the post-edge expectation, let one
    // edge pass, then return just after the following falling edge.
    task automatic step(input string name, input logic [3:0] ec,
                        input logic et, input logic eo);
        exp_t e;
        e.name = name; e.cnt = ec; e.tc = et; e.ovf = eo;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic ctl(input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic u, input logic s,
                       input logic [3:0] m);
        clr = c; load = l; load_val = lv; en = e; up = u; sat = s; mod_val = m;
    endtask

    initial begin
        rst_n = 1'b0;
        ctl(0, 0, 4'd0, 0, 1, 0, 4'd0);
        repeat (2) @(negedge clk);
        #1;

        // Reset value held across an edge while rst_n is low.
        step("reset", 4'd3, 0, 0);
        rst_n = 1'b1;
        step("release_idle", 4'd3, 0, 0);
        ctl(1, 0, 4'd0, 0, 1, 0, 4'd0);
        step("clr", 4'd0, 0, 0);

        // Full-range up count: 1..15, 0 (boundary), 1.
        ctl(0, 0, 4'd0, 1, 1, 0, 4'd0);
        for (int i = 1; i <= 15; i++) step("full_up", 4'(i), 0, 0);
        step("full_wrap", 4'd0, 1, 1);
        step("full_after", 4'd1, 0, 1);

        // Modulus 10, down, wrap.
        ctl(0, 1, 4'd2, 0, 0, 0, 4'd10);
        step("load2", 4'd2, 0, 1);
        ctl(0, 0, 4'd0, 1, 0, 0, 4'd10);
        step("dn1", 4'd1, 0, 1);
        step("dn0", 4'd0, 0, 1);
        step("dn_wrap", 4'd9, 1, 1);
        step("dn8", 4'd8, 0, 1);

        // Modulus 10, up, saturate.
        ctl(1, 0, 4'd0, 0, 1, 1, 4'd10);
        step("clr2", 4'd0, 0, 0);
        ctl(0, 1, 4'd8, 0, 1, 1, 4'd10);
        step("load8", 4'd8, 0, 0);
        ctl(0, 0, 4'd0, 1, 1, 1, 4'd10);
        step("sat9", 4'd9, 0, 0);
        step("sat_hold1", 4'd9, 1, 1);
        step("sat_hold2", 4'd9, 1, 1);

        // Priority and clamp.
        ctl(0, 1, 4'd14, 1, 1, 0, 4'd10);
        step("load_clamp", 4'd9, 0, 1);
        ctl(1, 1, 4'd5, 1, 1, 0, 4'd10);
        step("clr_over_load", 4'd0, 0, 0);

        // Runtime modulus shrink below the current count.
        ctl(0, 1, 4'd12, 0, 1, 0, 4'd0);
        step("load12", 4'd12, 0, 0);
        ctl(0, 0, 4'd0, 1, 1, 0, 4'd5);
        step("shrink_recover", 4'd0, 0, 0);
        for (int i = 1; i <= 4; i++) step("mod5_up", 4'(i), 0, 0);
        step("mod5_wrap", 4'd0, 1, 1);

        // Saturate down at zero.
        ctl(1, 0, 4'd0, 0, 0, 1, 4'd0);
        step("clr3", 4'd0, 0, 0);
        ctl(0, 0, 4'd0, 1, 0, 1, 4'd0);
        step("sat_dn0", 4'd0, 1, 1);

        // mod_val = 1: every enabled step is a boundary.
        ctl(0, 0, 4'd0, 1, 1, 0, 4'd1);
        step("mod1_a", 4'd0, 1, 1);
        step("mod1_b", 4'd0, 1, 1);
        ctl(0, 0, 4'd0, 0, 1, 0, 4'd1);
        step("mod1_idle", 4'd0, 0, 1);

        // Asynchronous reset mid-count at cnt=7.
        ctl(0, 1, 4'd7, 0, 1, 0, 4'd0);
        step("load7", 4'd7, 0, 1);
        ctl(0, 0, 4'd0, 1, 1, 0, 4'd0);
        rst_n = 1'b0;
        #1;
        compare("async_reset", 4'd3, 0, 0);
        #1;
        rst_n = 1'b1;
        step("resume4", 4'd4, 0, 0);
        step("resume5", 4'd5, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
